branch_resolve_unit: RTL and testbench

- Downstream companion of the global (gshare) branch predictor.
- Carries each decoded branch and its D-stage prediction through the E and M pipeline stages, evaluates the branch condition in E, and registers the outcome into M.
- Produces the update/recovery signals the predictor consumes (actual_takeE, branchM, actual_takeM, pred_wrong, pcM), the fetch redirect, the front-end flush and saturating accuracy counters.

---
 rtl/branch_resolve_unit.sv | 176 +++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//   Carries each decoded branch and its D-stage gshare prediction through the
//   E and M stages, evaluates the branch condition in E, registers the outcome
//   into M, and produces the predictor update / fetch recovery signals along
//   with saturating branch and misprediction counters.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   stallE, stallM           hold the D->E / E->M pipeline registers
//   flushE                   load a bubble into the E register
//   branchD, pred_takeD      D-stage branch flag and predicted direction
//   branch_opD               branch condition selector
//   pcD, targetD             D-stage branch PC and taken target
//   rs_valE, rt_valE         forwarded operands in E
//   actual_takeE             combinational E-stage outcome
//   branchM, actual_takeM    M-stage branch (reported once) and its outcome
//   pred_wrong, pcM          M-stage misprediction and branch PC
//   redirect, redirect_pc    fetch redirect request and address
//   flush_fd                 flush F and D stage registers
//   cnt_branch, cnt_mispred  saturating resolved-branch / mispredict counters
module branch_resolve_unit #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stallE,
  input  logic                 stallM,
  input  logic                 flushE,
  input  logic                 branchD,
  input  logic                 pred_takeD,
  input  logic [2:0]           branch_opD,
  input  logic [31:0]          pcD,
  input  logic [31:0]          targetD,
  input  logic [31:0]          rs_valE,
  input  logic [31:0]          rt_valE,
  output logic                 actual_takeE,
  output logic                 branchM,
  output logic                 actual_takeM,
  output logic                 pred_wrong,
  output logic [31:0]          pcM,
  output logic                 redirect,
  output logic [31:0]          redirect_pc,
  output logic                 flush_fd,
  output logic [CNT_WIDTH-1:0] cnt_branch,
  output logic [CNT_WIDTH-1:0] cnt_mispred
);

  typedef enum logic [2:0] {
    OP_BEQ    = 3'b000,
    OP_BNE    = 3'b001,
    OP_BGEZ   = 3'b010,
    OP_BGTZ   = 3'b011,
    OP_BLEZ   = 3'b100,
    OP_BLTZ   = 3'b101,
    OP_ALWAYS = 3'b110,
    OP_NEVER  = 3'b111
  } br_op_e;

  // E stage register
  logic        r_validE;
  logic        r_pred_takeE;
  br_op_e      r_opE;
  logic [31:0] r_pcE;
  logic [31:0] r_targetE;

  // M stage register
  logic        r_validM;
  logic        r_pred_takeM;
  logic        r_actual_takeM;
  logic [31:0] r_pcM;
  logic [31:0] r_targetM;

  logic [CNT_WIDTH-1:0] r_cnt_branch;
  logic [CNT_WIDTH-1:0] r_cnt_mispred;

  logic w_cond;
  logic w_rs_neg;
  logic w_rs_zero;
  logic w_mis;
  logic w_branchM;
  logic w_pred_wrong;

  // A misprediction resolving in M kills the wrong-path instruction in D,
  // so E takes a bubble on that edge just as it does for flushE.
  always_ff @(posedge clk) begin
    if (rst || flushE || w_pred_wrong) begin
      r_validE     <= 1'b0;
      r_pred_takeE <= 1'b0;
      r_opE        <= OP_BEQ;
      r_pcE        <= '0;
      r_targetE    <= '0;
    end else if (!stallE) begin
      r_validE     <= branchD;
      r_pred_takeE <= pred_takeD;
      r_opE        <= br_op_e'(branch_opD);
      r_pcE        <= pcD;
      r_targetE    <= targetD;
    end
  end

  assign w_rs_neg  = rs_valE[31];
  assign w_rs_zero = (rs_valE == '0);

  always_comb begin
    w_cond = 1'b0;
    case (r_opE)
      OP_BEQ:    w_cond = (rs_valE == rt_valE);
      OP_BNE:    w_cond = (rs_valE != rt_valE);
      OP_BGEZ:   w_cond = !w_rs_neg;
      OP_BGTZ:   w_cond = !w_rs_neg && !w_rs_zero;
      OP_BLEZ:   w_cond = w_rs_neg || w_rs_zero;
      OP_BLTZ:   w_cond = w_rs_neg;
      OP_ALWAYS: w_cond = 1'b1;
      OP_NEVER:  w_cond = 1'b0;
      default:   w_cond = 1'b0;
    endcase
  end

  assign actual_takeE = r_validE & w_cond;

  // E stalled while M advances: the E entry stays put, so M must see a bubble.
  always_ff @(posedge clk) begin
    if (rst || (!stallM && stallE)) begin
      r_validM       <= 1'b0;
      r_pred_takeM   <= 1'b0;
      r_actual_takeM <= 1'b0;
      r_pcM          <= '0;
      r_targetM      <= '0;
    end else if (!stallM) begin
      r_validM       <= r_validE;
      r_pred_takeM   <= r_pred_takeE;
      r_actual_takeM <= actual_takeE;
      r_pcM          <= r_pcE;
      r_targetM      <= r_targetE;
    end
  end

  // Reporting is gated by ~stallM so a branch held in M is counted and
  // redirected only on the cycle it finally advances.
  assign w_mis        = r_validM & (r_pred_takeM != r_actual_takeM);
  assign w_branchM    = r_validM & ~stallM;
  assign w_pred_wrong = w_mis & ~stallM;

  assign branchM      = w_branchM;
  assign pred_wrong   = w_pred_wrong;
  assign actual_takeM = r_actual_takeM;
  assign pcM          = r_pcM;
  assign redirect     = w_pred_wrong;
  assign flush_fd     = w_pred_wrong;

  // Not-taken recovery skips the delay slot at pcM+4, which is already in E.
  always_comb begin
    redirect_pc = '0;
    if (w_pred_wrong) begin
      redirect_pc = r_actual_takeM ? r_targetM : (r_pcM + 32'd8);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt_branch  <= '0;
      r_cnt_mispred <= '0;
    end else begin
      if (w_branchM && (r_cnt_branch != '1)) begin
        r_cnt_branch <= r_cnt_branch + CNT_WIDTH'(1);
      end
      if (w_pred_wrong && (r_cnt_mispred != '1)) begin
        r_cnt_mispred <= r_cnt_mispred + CNT_WIDTH'(1);
      end
    end
  end

  assign cnt_branch  = r_cnt_branch;
  assign cnt_mispred = r_cnt_mispred;

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallE = 1'b0;
  logic        stallM = 1'b0;
  logic        flushE = 1'b0;
  logic        branchD = 1'b0;
  logic        pred_takeD = 1'b0;
  logic [2:0]  branch_opD = 3'b000;
  logic [31:0] pcD = '0;
  logic [31:0] targetD = '0;
  logic [31:0] rs_valE = '0;
  logic [31:0] rt_valE = '0;

  logic        actual_takeE, branchM, actual_takeM, pred_wrong, redirect, flush_fd;
  logic [31:0] pcM, redirect_pc, cnt_branch, cnt_mispred;

  logic        w4_actual_takeE, w4_branchM, w4_actual_takeM, w4_pred_wrong;
  logic        w4_redirect, w4_flush_fd;
  logic [31:0] w4_pcM, w4_redirect_pc;
  logic [3:0]  w4_cnt_branch, w4_cnt_mispred;

  always #5 clk = ~clk;

  branch_resolve_unit #(.CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .stallE(stallE), .stallM(stallM), .flushE(flushE),
    .branchD(branchD), .pred_takeD(pred_takeD), .branch_opD(branch_opD),
    .pcD(pcD), .targetD(targetD), .rs_valE(rs_valE), .rt_valE(rt_valE),
    .actual_takeE(actual_takeE), .branchM(branchM), .actual_takeM(actual_takeM),
    .pred_wrong(pred_wrong), .pcM(pcM), .redirect(redirect),
    .redirect_pc(redirect_pc), .flush_fd(flush_fd),
    .cnt_branch(cnt_branch), .cnt_mispred(cnt_mispred)
  );

  branch_resolve_unit #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .stallE(stallE), .stallM(stallM), .flushE(flushE),
    .branchD(branchD), .pred_takeD(pred_takeD), .branch_opD(branch_opD),
    .pcD(pcD), .targetD(targetD), .rs_valE(rs_valE), .rt_valE(rt_valE),
    .actual_takeE(w4_actual_takeE), .branchM(w4_branchM),
    .actual_takeM(w4_actual_takeM), .pred_wrong(w4_pred_wrong), .pcM(w4_pcM),
    .redirect(w4_redirect), .redirect_pc(w4_redirect_pc), .flush_fd(w4_flush_fd),
    .cnt_branch(w4_cnt_branch), .cnt_mispred(w4_cnt_mispred)
  );

  typedef struct {
    logic        act;
    logic        pw;
    logic [31:0] pc;
    logic [31:0] rpc;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic        pred;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        act;
    logic        pw;
    logic [31:0] rpc;
    int          sE;
    int          sM;
    logic        wp;
  } vec_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int exp_br = 0;
  int exp_mis = 0;

  // Expected values computed by hand from the branch semantics.
  vec_t tbl [0:11] = '{
    '{3'b000, 1'b1, 32'hBFC00100, 32'hBFC00200, 32'd5,        32'd5, 1'b1, 1'b0, 32'h0,        0, 0, 1'b0},
    '{3'b001, 1'b1, 32'hBFC00100, 32'hBFC00200, 32'd5,        32'd5, 1'b0, 1'b1, 32'hBFC00108, 0, 0, 1'b1},
    '{3'b101, 1'b0, 32'h80000F00, 32'h80001000, 32'hFFFFFFFF, 32'd0, 1'b1, 1'b1, 32'h80001000, 0, 0, 1'b0},
    '{3'b011, 1'b0, 32'h80002000, 32'h80002400, 32'd7,        32'd0, 1'b1, 1'b1, 32'h80002400, 0, 3, 1'b0},
    '{3'b010, 1'b1, 32'h80003000, 32'h80003100, 32'd0,        32'd0, 1'b1, 1'b0, 32'h0,        2, 0, 1'b0},
    '{3'b100, 1'b0, 32'h80004000, 32'h80004800, 32'd0,        32'd0, 1'b1, 1'b1, 32'h80004800, 0, 0, 1'b0},
    '{3'b100, 1'b0, 32'h80005000, 32'h80005800, 32'd1,        32'd0, 1'b0, 1'b0, 32'h0,        0, 0, 1'b0},
    '{3'b011, 1'b1, 32'h80006000, 32'h80006800, 32'h80000000, 32'd0, 1'b0, 1'b1, 32'h80006008, 0, 0, 1'b1},
    '{3'b111, 1'b1, 32'h80007000, 32'h80007400, 32'd0,        32'd0, 1'b0, 1'b1, 32'h80007008, 0, 0, 1'b0},
    '{3'b110, 1'b1, 32'h80008000, 32'h80008400, 32'd0,        32'd0, 1'b1, 1'b0, 32'h0,        0, 0, 1'b0},
    '{3'b000, 1'b1, 32'h80009000, 32'h80009100, 32'd5,        32'd6, 1'b0, 1'b1, 32'h80009008, 0, 0, 1'b0},
    '{3'b010, 1'b0, 32'h8000A000, 32'h8000A200, 32'h80000000, 32'd0, 1'b0, 1'b0, 32'h0,        0, 0, 1'b0}
  };

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every reported branch must match the head of the scoreboard.
  always @(negedge clk) begin
    if (branchM === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_branchM: got branchM=1 expected no branch, pcM=0x%08h at %0t", pcM, $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("actual_takeM", {31'b0, actual_takeM}, {31'b0, e.act});
        chk("pred_wrong",   {31'b0, pred_wrong},   {31'b0, e.pw});
        chk("redirect",     {31'b0, redirect},     {31'b0, e.pw});
        chk("flush_fd",     {31'b0, flush_fd},     {31'b0, e.pw});
        chk("pcM",          pcM,                   e.pc);
        chk("redirect_pc",  redirect_pc,           e.rpc);
      end
    end else if ((pred_wrong | redirect | flush_fd) !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL idle_recovery: got pw/redir/flush=%b%b%b expected 000 at %0t",
               pred_wrong, redirect, flush_fd, $time);
    end
  end

  task automatic check_counts(input string tag);
    int sat_br, sat_mis;
    sat_br  = (exp_br  > 15) ? 15 : exp_br;
    sat_mis = (exp_mis > 15) ? 15 : exp_mis;
    @(negedge clk);
    chk({tag, "_cnt_branch"},   cnt_branch,             32'(exp_br));
    chk({tag, "_cnt_mispred"},  cnt_mispred,            32'(exp_mis));
    chk({tag, "_cnt4_branch"},  {28'b0, w4_cnt_branch},  32'(sat_br));
    chk({tag, "_cnt4_mispred"}, {28'b0, w4_cnt_mispred}, 32'(sat_mis));
  endtask

  task automatic check_all_zero(input string tag);
    @(negedge clk);
    chk({tag, "_outs"}, {26'b0, actual_takeE, branchM, actual_takeM, pred_wrong, redirect, flush_fd}, 32'h0);
    chk({tag, "_pcM"}, pcM, 32'h0);
    chk({tag, "_redirect_pc"}, redirect_pc, 32'h0);
    chk({tag, "_cnt_branch"}, cnt_branch, 32'h0);
    chk({tag, "_cnt_mispred"}, cnt_mispred, 32'h0);
  endtask

  task automatic issue(input vec_t v);
    exp_t e;
    // cycle A: branch in D
    @(posedge clk); #1;
    branchD = 1'b1; pred_takeD = v.pred; branch_opD = v.op; pcD = v.pc; targetD = v.tgt;
    e.act = v.act; e.pw = v.pw; e.pc = v.pc; e.rpc = v.rpc;
    q.push_back(e);
    exp_br++;
    if (v.pw) exp_mis++;
    // cycle B: branch in E
    @(posedge clk); #1;
    branchD = 1'b0; rs_valE = v.rs; rt_valE = v.rt;
    stallE = (v.sE > 0);
    for (int i = 0; i < v.sE; i++) begin
      @(negedge clk);
      chk("stallE_actual_takeE", {31'b0, actual_takeE}, {31'b0, v.act});
      chk("stallE_branchM", {31'b0, branchM}, 32'h0);
      @(posedge clk); #1;
    end
    stallE = 1'b0;
    @(negedge clk);
    chk("actual_takeE", {31'b0, actual_takeE}, {31'b0, v.act});
    // cycle C: branch in M; optionally a wrong-path branch sits in D
    @(posedge clk); #1;
    if (v.wp) begin
      branchD = 1'b1; branch_opD = 3'b110; pred_takeD = 1'b0;
    end
    stallM = (v.sM > 0);
    for (int i = 0; i < v.sM; i++) begin
      @(negedge clk);
      chk("stallM_branchM", {31'b0, branchM}, 32'h0);
      chk("stallM_pred_wrong", {31'b0, pred_wrong}, 32'h0);
      chk("stallM_redirect", {31'b0, redirect}, 32'h0);
      @(posedge clk); #1;
    end
    stallM = 1'b0;
    // cycle D
    @(posedge clk); #1;
    branchD = 1'b0;
    if (v.wp) begin
      @(negedge clk);
      chk("wrong_path_flushed", {31'b0, actual_takeE}, 32'h0);
    end
  endtask

  initial begin
    vec_t v;
    int guard;
    // reset state
    repeat (3) @(posedge clk);
    check_all_zero("reset");
    chk("reset_cnt4", {24'b0, w4_cnt_branch, w4_cnt_mispred}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      issue(tbl[i]);
      check_counts("vec");
    end

    // mid-run reset clears counters
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    exp_br = 0; exp_mis = 0;
    check_counts("rst_mid");

    // 20 mispredicted never-taken branches: 4-bit counters saturate at 15
    for (int i = 0; i < 20; i++) begin
      v = '{3'b111, 1'b1, 32'h80010000 + 32'(i * 16), 32'h80020000, 32'd0, 32'd0,
            1'b0, 1'b1, 32'h80010008 + 32'(i * 16), 0, 0, 1'b0};
      issue(v);
    end
    check_counts("sat");

    // flushE together with branchD: the branch never reaches E or M
    @(posedge clk); #1;
    branchD = 1'b1; branch_opD = 3'b110; pred_takeD = 1'b0; pcD = 32'h80030000;
    targetD = 32'h80030100; flushE = 1'b1;
    @(posedge clk); #1;
    branchD = 1'b0; flushE = 1'b0;
    @(negedge clk);
    chk("flushE_actual_takeE", {31'b0, actual_takeE}, 32'h0);
    repeat (3) @(posedge clk);
    check_counts("flushE");

    // rst while a branch is in E: it is discarded, everything returns to 0
    @(posedge clk); #1;
    branchD = 1'b1; branch_opD = 3'b110; pred_takeD = 1'b0; pcD = 32'h80040000;
    targetD = 32'h80040100;
    @(posedge clk); #1;
    branchD = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("pre_rst_actual_takeE", {31'b0, actual_takeE}, 32'h1);
    @(posedge clk); #1;
    check_all_zero("rst_inE");
    rst = 1'b0;
    repeat (4) @(posedge clk);
    exp_br = 0; exp_mis = 0;
    check_counts("rst_inE");

    guard = 0;
    while (q.size() != 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending branches expected 0", q.size());
    end
    checks++;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
